// File: rtl/pc_select_unit_if.sv
// Bus between the IF-stage next-PC unit and the control/hazard logic that feeds it.
// The unit itself connects through the slave modport.
interface pc_select_unit_if #(
    parameter int WIDTH = 32
);
    logic             stall;
    logic             branch_take;
    logic [WIDTH-1:0] bta;
    logic             jump;
    logic [WIDTH-1:0] jump_addr;
    logic             jr;
    logic [WIDTH-1:0] jr_addr;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_plus_step;
    logic             flush;
    logic             pending;
    logic             misalign_err;

    modport master (
        output stall, branch_take, bta, jump, jump_addr, jr, jr_addr,
        input  pc, pc_plus_step, flush, pending, misalign_err
    );

    modport slave (
        input  stall, branch_take, bta, jump, jump_addr, jr, jr_addr,
        output pc, pc_plus_step, flush, pending, misalign_err
    );
endinterface

// File: rtl/pc_select_unit.sv
// Next-PC selection for the IF stage: owns the PC register, picks
// jr > jump > branch targets, parks a redirect seen during a stall until the
// stall releases, and pulses flush after every non-sequential PC load.
module pc_select_unit #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int unsigned      STEP         = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    pc_select_unit_if.slave bus
);
    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] pend_addr_q, pend_addr_d;
    logic             pending_q, pending_d;
    logic             flush_q, flush_d;
    logic             misalign_q, misalign_d;

    logic             req;
    logic [WIDTH-1:0] sel_raw;
    logic [WIDTH-1:0] sel_addr;

    // Priority select of the redirect target; low two bits are forced to a word boundary
    always_comb begin
        req = bus.jr | bus.jump | bus.branch_take;
        if (bus.jr) begin
            sel_raw = bus.jr_addr;
        end else if (bus.jump) begin
            sel_raw = bus.jump_addr;
        end else begin
            sel_raw = bus.bta;
        end
        sel_addr = {sel_raw[WIDTH-1:2], 2'b00};
    end

    // State register: PC, parked redirect, flush pulse and sticky alignment error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= RESET_VECTOR;
            pend_addr_q <= '0;
            pending_q   <= 1'b0;
            flush_q     <= 1'b0;
            misalign_q  <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            pend_addr_q <= pend_addr_d;
            pending_q   <= pending_d;
            flush_q     <= flush_d;
            misalign_q  <= misalign_d;
        end
    end

    // Next state: a parked redirect beats any fresh request, which belongs to a squashed instruction
    always_comb begin
        pc_d        = pc_q;
        pend_addr_d = pend_addr_q;
        pending_d   = pending_q;
        flush_d     = 1'b0;
        misalign_d  = misalign_q;
        if (!bus.stall) begin
            if (pending_q) begin
                pc_d      = pend_addr_q;
                pending_d = 1'b0;
                flush_d   = 1'b1;
            end else if (req) begin
                pc_d    = sel_addr;
                flush_d = 1'b1;
                if (sel_raw[1:0] != 2'b00) begin
                    misalign_d = 1'b1;
                end
            end else begin
                pc_d = pc_q + STEP_W;
            end
        end else if (req && !pending_q) begin
            // First redirect during a stall is parked; later ones are ignored
            pend_addr_d = sel_addr;
            pending_d   = 1'b1;
            if (sel_raw[1:0] != 2'b00) begin
                misalign_d = 1'b1;
            end
        end
    end

    // Outputs: everything registered except the sequential-address adder off pc
    always_comb begin
        bus.pc           = pc_q;
        bus.pc_plus_step = pc_q + STEP_W;
        bus.flush        = flush_q;
        bus.pending      = pending_q;
        bus.misalign_err = misalign_q;
    end
endmodule

// File: tb/tb_pc_select_unit.sv
module tb_pc_select_unit;
    localparam logic [31:0] RV = 32'h0040_0000;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    pc_select_unit_if #(.WIDTH(32)) bus ();

    pc_select_unit #(.WIDTH(32), .RESET_VECTOR(RV), .STEP(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        bt;
        logic [31:0] bta;
        logic        jump;
        logic [31:0] ja;
        logic        jr;
        logic [31:0] jra;
        logic [31:0] e_pc;
        logic        e_flush;
        logic        e_pend;
        logic        e_err;
    } vec_t;

    vec_t vecs[21];

    // Reference model: pending redirect kept as a queue of at most one address
    logic [31:0] m_pc;
    logic [31:0] m_pendq[$];
    logic        m_flush;
    logic        m_err;
    bit          use_model;

    function automatic vec_t mk(logic st, logic bt, logic [31:0] bta, logic jp, logic [31:0] ja,
                                logic jr, logic [31:0] jra, logic [31:0] epc, logic ef,
                                logic ep, logic ee);
        vec_t v;
        v.stall = st; v.bt = bt; v.bta = bta; v.jump = jp; v.ja = ja; v.jr = jr; v.jra = jra;
        v.e_pc = epc; v.e_flush = ef; v.e_pend = ep; v.e_err = ee;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(logic st, logic bt, logic [31:0] bta, logic jp, logic [31:0] ja,
                         logic jr, logic [31:0] jra);
        bus.stall = st; bus.branch_take = bt; bus.bta = bta;
        bus.jump = jp; bus.jump_addr = ja; bus.jr = jr; bus.jr_addr = jra;
    endtask

    task automatic model_edge();
        logic [31:0] tgt;
        logic        req;
        req = bus.jr | bus.jump | bus.branch_take;
        tgt = bus.jr ? bus.jr_addr : (bus.jump ? bus.jump_addr : bus.bta);
        if (!bus.stall) begin
            if (m_pendq.size() != 0) begin
                m_pc = m_pendq.pop_front();
                m_flush = 1'b1;
            end else if (req) begin
                m_pc = tgt & ~32'h3;
                m_flush = 1'b1;
                if ((tgt % 4) != 0) m_err = 1'b1;
            end else begin
                m_pc = m_pc + 32'd4;
                m_flush = 1'b0;
            end
        end else begin
            m_flush = 1'b0;
            if (req && m_pendq.size() == 0) begin
                m_pendq.push_back(tgt & ~32'h3);
                if ((tgt % 4) != 0) m_err = 1'b1;
            end
        end
    endtask

    task automatic model_reset();
        m_pc = RV;
        m_pendq.delete();
        m_flush = 1'b0;
        m_err = 1'b0;
    endtask

    // One clock edge; outputs are sampled 1 ns after the rising edge
    task automatic tick();
        @(posedge clk);
        if (use_model) model_edge();
        #1;
    endtask

    task automatic chk_model(int n);
        chk("pc", bus.pc, m_pc);
        chk("pc_plus_step", bus.pc_plus_step, m_pc + 32'd4);
        chk("flush", 32'(bus.flush), 32'(m_flush));
        chk("pending", 32'(bus.pending), 32'(m_pendq.size() != 0));
        chk("misalign_err", 32'(bus.misalign_err), 32'(m_err));
        $display("[TB] rnd %0d stall=%b jr=%b j=%b b=%b pc=%h flush=%b pend=%b err=%b",
                 n, bus.stall, bus.jr, bus.jump, bus.branch_take, bus.pc, bus.flush,
                 bus.pending, bus.misalign_err);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        use_model = 1'b0;
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);

        vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 32'h0040_0004, 0, 0, 0);
        vecs[1]  = mk(0, 0, 0, 0, 0, 0, 0, 32'h0040_0008, 0, 0, 0);
        vecs[2]  = mk(0, 0, 0, 0, 0, 0, 0, 32'h0040_000C, 0, 0, 0);
        vecs[3]  = mk(0, 0, 0, 0, 0, 1, 32'h100, 32'h100, 1, 0, 0);
        vecs[4]  = mk(0, 1, 32'h180, 1, 32'h200, 1, 32'h300, 32'h300, 1, 0, 0);
        vecs[5]  = mk(0, 0, 0, 0, 0, 1, 32'h100, 32'h100, 1, 0, 0);
        vecs[6]  = mk(0, 1, 32'h180, 1, 32'h200, 0, 0, 32'h200, 1, 0, 0);
        vecs[7]  = mk(0, 0, 0, 0, 0, 0, 0, 32'h204, 0, 0, 0);
        vecs[8]  = mk(1, 1, 32'h480, 0, 0, 0, 0, 32'h204, 0, 1, 0);
        vecs[9]  = mk(1, 0, 0, 1, 32'h900, 0, 0, 32'h204, 0, 1, 0);
        vecs[10] = mk(1, 0, 0, 0, 0, 0, 0, 32'h204, 0, 1, 0);
        vecs[11] = mk(0, 0, 0, 0, 0, 0, 0, 32'h480, 1, 0, 0);
        vecs[12] = mk(0, 0, 0, 0, 0, 0, 0, 32'h484, 0, 0, 0);
        vecs[13] = mk(1, 1, 32'h600, 0, 0, 0, 0, 32'h484, 0, 1, 0);
        vecs[14] = mk(0, 0, 0, 0, 0, 1, 32'h700, 32'h600, 1, 0, 0);
        vecs[15] = mk(0, 0, 0, 0, 0, 0, 0, 32'h604, 0, 0, 0);
        vecs[16] = mk(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 0, 0);
        vecs[17] = mk(0, 0, 0, 0, 0, 0, 0, 32'h0000_0000, 0, 0, 0);
        vecs[18] = mk(0, 1, 32'h1002, 0, 0, 0, 0, 32'h1000, 1, 0, 1);
        vecs[19] = mk(0, 0, 0, 0, 0, 0, 0, 32'h1004, 0, 0, 1);
        vecs[20] = mk(1, 0, 0, 1, 32'h2000, 0, 0, 32'h1004, 0, 1, 1);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_pc", bus.pc, RV);
        chk("reset_pc_plus_step", bus.pc_plus_step, RV + 32'd4);
        chk("reset_flush", 32'(bus.flush), 32'd0);
        chk("reset_pending", 32'(bus.pending), 32'd0);
        chk("reset_err", 32'(bus.misalign_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors
        for (int i = 0; i < 21; i++) begin
            drive(vecs[i].stall, vecs[i].bt, vecs[i].bta, vecs[i].jump, vecs[i].ja,
                  vecs[i].jr, vecs[i].jra);
            tick();
            chk($sformatf("vec%0d_pc", i), bus.pc, vecs[i].e_pc);
            chk($sformatf("vec%0d_pc_plus_step", i), bus.pc_plus_step, vecs[i].e_pc + 32'd4);
            chk($sformatf("vec%0d_flush", i), 32'(bus.flush), 32'(vecs[i].e_flush));
            chk($sformatf("vec%0d_pending", i), 32'(bus.pending), 32'(vecs[i].e_pend));
            chk($sformatf("vec%0d_err", i), 32'(bus.misalign_err), 32'(vecs[i].e_err));
            $display("[TB] vec %0d pc=%h flush=%b pend=%b err=%b", i, bus.pc, bus.flush,
                     bus.pending, bus.misalign_err);
        end

        // Asynchronous reset between edges while a redirect is parked
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_pc", bus.pc, RV);
        chk("async_rst_pending", 32'(bus.pending), 32'd0);
        chk("async_rst_flush", 32'(bus.flush), 32'd0);
        chk("async_rst_err", 32'(bus.misalign_err), 32'd0);
        $display("[TB] async reset pc=%h pend=%b", bus.pc, bus.pending);
        @(negedge clk);
        rst_n = 1'b1;

        // First edge after reset honours a request; discarded 0x2000 never appears
        drive(0, 0, 0, 1, 32'h800, 0, 0);
        tick();
        chk("post_rst_pc", bus.pc, 32'h800);
        chk("post_rst_flush", 32'(bus.flush), 32'd1);
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("post_rst_seq_pc", bus.pc, 32'h804);
        chk("post_rst_seq_flush", 32'(bus.flush), 32'd0);
        $display("[TB] post-reset redirect pc=%h", bus.pc);

        // Randomised run against the reference model
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        model_reset();
        use_model = 1'b1;
        for (int n = 0; n < 400; n++) begin
            logic [31:0] a0, a1, a2;
            a0 = {20'h0, $urandom_range(0, 1023), 2'b00};
            a1 = {20'h0, $urandom_range(0, 1023), 2'b00};
            a2 = {20'h0, $urandom_range(0, 1023), 2'b00};
            if ($urandom_range(0, 31) == 0) a0[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 31) == 0) a1[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 31) == 0) a2[1:0] = 2'($urandom_range(1, 3));
            drive(($urandom_range(0, 9) < 4), ($urandom_range(0, 3) == 0), a0,
                  ($urandom_range(0, 5) == 0), a1, ($urandom_range(0, 7) == 0), a2);
            tick();
            chk_model(n);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
